boot_loader_ctrl: RTL
=====================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit (even, >=4).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the input synchroniser depth.
REQ-003 SHALL have one clock and an asynchronous active-low reset, named as in the codebase:
- clk  in  1  single clock
- reset  in  1  asynchronous active-low reset
REQ-004 SHALL have the following ports:
- serial_in  in  1  async 8N1 byte stream, idle high
- start  out  1  processor run enable, held high once asserted
- busy  out  1  high whenever the FSM is not IDLE or RUN
- err  out  1  sticky protocol/framing error
- instr_mem_csb  out  [0:7]  active-low bank select, driven from addr[12:10]
- instrw_enb  out  1  active-low instruction write enable
- instr_wmask  out  4  byte mask
- instr_mem_addr_9bit  out  9  addr[9:1]
- instr_write_data  out  16  word to write
- data_mem_csb  out  1  active-low data chip select
- dataw_enb  out  1  active-low data write enable
- data_wmask  out  4  fixed 4'b0011
- data_mem_addr  out  8  addr[7:0]
- data_write_data  out  16  word to write

Function
REQ-005 SHALL pass serial_in through SYNC_STAGES flops; all receiver logic SHALL use only the synchronised value.
REQ-006 Receiver, when idle: on a synchronised falling edge, wait CLKS_PER_BIT/2 cycles and re-sample. If low, accept the start bit; if high, ignore the edge.
REQ-007 Receiver SHALL then sample 8 data bits, LSB first, then the stop bit, each CLKS_PER_BIT cycles apart, and raise byte_valid for one cycle after the stop-bit sample.
REQ-008 A stop bit of 0 SHALL set err, discard the byte, and return the FSM to IDLE.
REQ-009 FSM states: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DAT_H, DAT_L, WRITE, RUN. Each byte-driven state advances only on byte_valid.
REQ-010 IDLE command decode:
- 0xA5 -> target=instr, go to ADDR_H
- 0x5A -> target=data, go to ADDR_H
- 0xC3 -> RUN
- any other byte -> set err, stay in IDLE
REQ-011 ADDR_H and ADDR_L SHALL load a 16-bit address register (high byte first); only bits [12:0] are used.
REQ-012 CNT_H and CNT_L SHALL load a 16-bit word count. If the count is 0, go to IDLE with no write; otherwise go to DAT_H.
REQ-013 DAT_H and DAT_L SHALL capture the high and low byte. The last byte_valid in DAT_L moves the FSM to WRITE.
REQ-014 WRITE SHALL last exactly one cycle, driving the selected target:
- Instr target: instrw_enb=0; instr_mem_csb low only for bank addr[12:10]; instr_wmask={a0,a0,~a0,~a0}; write data={hi,lo}.
- Data target: dataw_enb=0, data_mem_csb=0.
REQ-015 On leaving WRITE: address += 1 and count -= 1. Go to IDLE if the new count is 0, else to DAT_H.
REQ-016 Address wrap: the instr address SHALL wrap 8191->0; the data address SHALL wrap 255->0.
REQ-017 Outside WRITE, all enables and chip selects SHALL be high (inactive); address and data outputs hold their last values.
REQ-018 RUN: start=1 from the first cycle in RUN. All received bytes are ignored, no writes occur, and only reset exits RUN.
REQ-019 err SHALL be set only by REQ-008 and REQ-010, and cleared only by reset.

Reset
REQ-020 Asserting reset SHALL immediately set:
- FSM=IDLE, receiver idle, synchroniser flops=1
- start=0, busy=0, err=0
- all enb/csb=1, addr/count/data registers=0
REQ-021 Reset asserted mid-frame or mid-load SHALL abort with no further write. The block SHALL be ready for a new frame on the first clk edge after release.

Structure
REQ-022 A shared package SHALL hold: the command byte constants, the FSM state enum, and the NOP/bank-count constants.
REQ-023 The serial byte receiver SHALL be a separate sub-module, uart_rx_byte (ports: clk, reset, rx, byte_valid, byte_data, frame_err).

Verification
REQ-024 Reset then idle line -> start=0, err=0, instrw_enb=1, dataw_enb=1, instr_mem_csb=8'hFF.
REQ-025 Send A5 00 02 00 02 12 34 AB CD -> two one-cycle writes:
- bank0, addr9=1, wmask=0011, data=1234
- bank0, addr9=1, wmask=1100, data=ABCD
- then IDLE
REQ-026 Send 5A 00 FF 00 02 11 11 22 22 -> data writes at 0xFF (1111) then 0x00 (2222), data_wmask=0011.
REQ-027 Send A5 04 00 00 01 BE EF -> only instr_mem_csb[1] low during the write; addr9=0; data=BEEF.
REQ-028 Frame with stop bit 0, then byte 0x77 -> err=1 with no write. Follow with A5 00 00 00 01 00 01 -> write still occurs.
REQ-029 Send C3, then A5 00 00 00 01 55 55 -> start=1 and no writes. Assert reset -> start=0.

Source files
------------

// File: rtl/boot_loader_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the serial boot loader.
package boot_loader_ctrl_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned COUNT_W   = 16;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned BANK_W    = 3;
  localparam int unsigned NUM_BANKS = 8;

  // Command bytes accepted in IDLE
  localparam logic [BYTE_W-1:0] CMD_INSTR = 8'hA5;
  localparam logic [BYTE_W-1:0] CMD_DATA  = 8'h5A;
  localparam logic [BYTE_W-1:0] CMD_RUN   = 8'hC3;

  // Inactive (NOP) levels for the memory strobes
  localparam logic [0:NUM_BANKS-1] CSB_NOP    = '1;
  localparam logic                 ENB_NOP    = 1'b1;
  localparam logic [3:0]           DATA_WMASK = 4'b0011;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DAT_H,
    ST_DAT_L,
    ST_WRITE,
    ST_RUN
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // One-cold bank select: only the addressed bank is pulled low
  function automatic logic [0:NUM_BANKS-1] bank_csb(input logic [BANK_W-1:0] bank);
    logic [0:NUM_BANKS-1] csb;
    csb       = CSB_NOP;
    csb[bank] = 1'b0;
    return csb;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with input synchroniser and mid-bit sampling.
module uart_rx_byte
  import boot_loader_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   prev_q;

  rx_state_t         rstate_q, rstate_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [2:0]        bit_q, bit_n;
  logic [BYTE_W-1:0] shreg_q, shreg_n;
  logic              valid_n, ferr_n;
  logic [BYTE_W-1:0] data_n;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; idles high so reset does not look like a start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= rx;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= rx_s;
    end
  end

  // Receiver state register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate_q   <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      byte_data  <= '0;
    end else begin
      rstate_q   <= rstate_n;
      cnt_q      <= cnt_n;
      bit_q      <= bit_n;
      shreg_q    <= shreg_n;
      byte_valid <= valid_n;
      frame_err  <= ferr_n;
      byte_data  <= data_n;
    end
  end

  // Next-state: qualify start at half bit, then sample every full bit
  always_comb begin
    rstate_n = rstate_q;
    cnt_n    = cnt_q;
    bit_n    = bit_q;
    shreg_n  = shreg_q;
    valid_n  = 1'b0;
    ferr_n   = 1'b0;
    data_n   = byte_data;
    unique case (rstate_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          rstate_n = RX_START;
          cnt_n    = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            rstate_n = RX_DATA;
            cnt_n    = FULL_RELOAD;
            bit_n    = 3'd0;
          end else begin
            rstate_n = RX_IDLE;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shreg_n = {rx_s, shreg_q[BYTE_W-1:1]};
          cnt_n   = FULL_RELOAD;
          if (bit_q == 3'd7) begin
            rstate_n = RX_STOP;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          rstate_n = RX_IDLE;
          if (rx_s) begin
            valid_n = 1'b1;
            data_n  = shreg_q;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: rstate_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Serial boot loader: decodes a byte protocol and writes instr/data memories.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic                 start,
  output logic                 busy,
  output logic                 err,
  output logic [0:NUM_BANKS-1] instr_mem_csb,
  output logic                 instrw_enb,
  output logic [3:0]           instr_wmask,
  output logic [8:0]           instr_mem_addr_9bit,
  output logic [WORD_W-1:0]    instr_write_data,
  output logic                 data_mem_csb,
  output logic                 dataw_enb,
  output logic [3:0]           data_wmask,
  output logic [7:0]           data_mem_addr,
  output logic [WORD_W-1:0]    data_write_data
);

  logic              rx_valid;
  logic              rx_ferr;
  logic [BYTE_W-1:0] rx_data;

  boot_state_t        state_q, state_n;
  logic               target_instr_q, target_instr_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [COUNT_W-1:0] count_q, count_n;
  logic [BYTE_W-1:0]  data_hi_q, data_hi_n;
  logic               err_set_c;
  logic [WORD_W-1:0]  wr_word_c;
  logic [COUNT_W-1:0] cnt_load_c;
  logic [7:0]         daddr_inc_c;
  logic [ADDR_W-1:0]  addr_inc_c;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (serial_in),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_ferr)
  );

  // Data-memory byte mask is fixed
  assign data_wmask = DATA_WMASK;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  // Load registers: target, address, count and high data byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_instr_q <= 1'b0;
      addr_q         <= '0;
      count_q        <= '0;
      data_hi_q      <= '0;
    end else begin
      target_instr_q <= target_instr_n;
      addr_q         <= addr_n;
      count_q        <= count_n;
      data_hi_q      <= data_hi_n;
    end
  end

  // Next-state and load decode; a framing error aborts back to IDLE
  always_comb begin
    state_n        = state_q;
    target_instr_n = target_instr_q;
    addr_n         = addr_q;
    count_n        = count_q;
    data_hi_n      = data_hi_q;
    err_set_c      = 1'b0;
    wr_word_c      = {data_hi_q, rx_data};
    cnt_load_c     = {count_q[COUNT_W-1:8], rx_data};
    daddr_inc_c    = addr_q[7:0] + 8'd1;
    addr_inc_c     = target_instr_q ? (addr_q + ADDR_W'(1))
                                    : {(ADDR_W-8)'(0), daddr_inc_c};
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            CMD_INSTR: begin
              target_instr_n = 1'b1;
              state_n        = ST_ADDR_H;
            end
            CMD_DATA: begin
              target_instr_n = 1'b0;
              state_n        = ST_ADDR_H;
            end
            CMD_RUN: state_n = ST_RUN;
            default: err_set_c = 1'b1;
          endcase
        end
      end
      ST_ADDR_H: begin
        if (rx_valid) begin
          addr_n  = {rx_data[ADDR_W-9:0], addr_q[7:0]};
          state_n = ST_ADDR_L;
        end
      end
      ST_ADDR_L: begin
        if (rx_valid) begin
          addr_n  = {addr_q[ADDR_W-1:8], rx_data};
          state_n = ST_CNT_H;
        end
      end
      ST_CNT_H: begin
        if (rx_valid) begin
          count_n = {rx_data, count_q[7:0]};
          state_n = ST_CNT_L;
        end
      end
      ST_CNT_L: begin
        if (rx_valid) begin
          count_n = cnt_load_c;
          state_n = (cnt_load_c == '0) ? ST_IDLE : ST_DAT_H;
        end
      end
      ST_DAT_H: begin
        if (rx_valid) begin
          data_hi_n = rx_data;
          state_n   = ST_DAT_L;
        end
      end
      ST_DAT_L: begin
        if (rx_valid) state_n = ST_WRITE;
      end
      ST_WRITE: begin
        addr_n  = addr_inc_c;
        count_n = count_q - COUNT_W'(1);
        state_n = (count_q == COUNT_W'(1)) ? ST_IDLE : ST_DAT_H;
      end
      ST_RUN: state_n = ST_RUN;
      default: state_n = ST_IDLE;
    endcase
    if (rx_ferr && state_q != ST_RUN) begin
      err_set_c = 1'b1;
      state_n   = ST_IDLE;
    end
  end

  // Registered outputs; strobes go active only for the single WRITE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start               <= 1'b0;
      busy                <= 1'b0;
      err                 <= 1'b0;
      instr_mem_csb       <= CSB_NOP;
      instrw_enb          <= ENB_NOP;
      instr_wmask         <= '0;
      instr_mem_addr_9bit <= '0;
      instr_write_data    <= '0;
      data_mem_csb        <= ENB_NOP;
      dataw_enb           <= ENB_NOP;
      data_mem_addr       <= '0;
      data_write_data     <= '0;
    end else begin
      start         <= (state_n == ST_RUN);
      busy          <= (state_n != ST_IDLE) && (state_n != ST_RUN);
      instr_mem_csb <= CSB_NOP;
      instrw_enb    <= ENB_NOP;
      data_mem_csb  <= ENB_NOP;
      dataw_enb     <= ENB_NOP;
      if (err_set_c) err <= 1'b1;
      if (state_n == ST_WRITE) begin
        if (target_instr_q) begin
          instrw_enb          <= 1'b0;
          instr_mem_csb       <= bank_csb(addr_q[ADDR_W-1:ADDR_W-BANK_W]);
          instr_wmask         <= {addr_q[0], addr_q[0], ~addr_q[0], ~addr_q[0]};
          instr_mem_addr_9bit <= addr_q[9:1];
          instr_write_data    <= wr_word_c;
        end else begin
          dataw_enb       <= 1'b0;
          data_mem_csb    <= 1'b0;
          data_mem_addr   <= addr_q[7:0];
          data_write_data <= wr_word_c;
        end
      end
    end
  end

endmodule
